// File: rtl/lfsr_xor_cipher.sv
// lfsr_xor_cipher: 6-bit LFSR keystream XOR stage that refuses input after REKEY_LIMIT words.
// Optional macro CIPHER_ZERO_SEED_GUARD_EN substitutes 6'b000001 for an all-zero seed.
module lfsr_xor_cipher #(
  parameter int unsigned REKEY_LIMIT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] key_in,
  input  logic       key_load,
  input  logic [5:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [5:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       keyed,
  output logic       expired,
  output logic [5:0] word_cnt
);

  typedef enum logic [1:0] {
    UNKEYED,
    RUN,
    EXPIRED
  } state_e;

  localparam logic [5:0] LIMIT = 6'(REKEY_LIMIT);

  state_e     state_q;
  logic [5:0] lfsr_q;
  logic [5:0] lfsr_d;
  logic [5:0] seed;
  logic [5:0] data_q;
  logic [5:0] cnt_q;
  logic [5:0] cnt_d;
  logic       valid_q;
  logic       xfer;

`ifdef CIPHER_ZERO_SEED_GUARD_EN
  assign seed = (key_in == '0) ? 6'b000001 : key_in;
`else
  assign seed = key_in;
`endif

  assign in_ready = (state_q == RUN) && !key_load && (!valid_q || out_ready);
  assign xfer     = in_valid && in_ready;
  assign lfsr_d   = {lfsr_q[0] ^ lfsr_q[1], lfsr_q[5:1]};
  assign cnt_d    = cnt_q + 6'd1;

  assign keyed     = (state_q == RUN);
  assign expired   = (state_q == EXPIRED);
  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign word_cnt  = cnt_q;

  // key_load outranks transfers and drains; a drain only matters when nothing new is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNKEYED;
      lfsr_q  <= 6'b000001;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (key_load) begin
      state_q <= RUN;
      lfsr_q  <= seed;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      data_q  <= data_in ^ lfsr_q;
      valid_q <= 1'b1;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      if (cnt_d == LIMIT) begin
        state_q <= EXPIRED;
      end
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_xor_cipher.sv
// Bench for lfsr_xor_cipher (REKEY_LIMIT=4): directed test-plan steps, then random traffic
// checked against a seed/index keystream reference model.
module tb_lfsr_xor_cipher;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] key_in;
  logic       key_load;
  logic [5:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       keyed;
  logic       expired;
  logic [5:0] word_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 unkeyed, 1 run, 2 expired; keystream word n derived from the seed
  int         m_mode;
  int         m_n;
  logic [5:0] m_seed;
  logic [5:0] m_dout;
  logic       m_vld;

  logic [5:0] ct0, ct1;
  logic [5:0] held;

  lfsr_xor_cipher #(.REKEY_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_load (key_load),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .keyed    (keyed),
    .expired  (expired),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ks(input logic [5:0] seed, input int n);
    logic [5:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = {s[0] ^ s[1], s[5:1]};
    return s;
  endfunction

  function automatic logic [5:0] eff_seed(input logic [5:0] k);
`ifdef CIPHER_ZERO_SEED_GUARD_EN
    return (k == 6'd0) ? 6'd1 : k;
`else
    return k;
`endif
  endfunction

  task automatic check6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready for the driven inputs, advance the model, check registered outputs.
  task automatic cyc();
    logic rdy;
    #1;
    rdy = (m_mode == 1) && !key_load && (!m_vld || out_ready);
    if (!rst) check1("in_ready", in_ready, rdy);
    if (rst) begin
      m_mode = 0; m_n = 0; m_vld = 1'b0; m_dout = '0;
    end else if (key_load) begin
      m_mode = 1; m_n = 0; m_vld = 1'b0; m_seed = eff_seed(key_in);
    end else if (in_valid && rdy) begin
      m_dout = data_in ^ ks(m_seed, m_n);
      m_vld  = 1'b1;
      m_n++;
      if (m_n == LIMIT) m_mode = 2;
    end else if (m_vld && out_ready) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    check1("out_valid", out_valid, m_vld);
    check6("data_out", data_out, m_dout);
    check6("word_cnt", word_cnt, 6'(m_n));
    check1("keyed", keyed, m_mode == 1);
    check1("expired", expired, m_mode == 2);
  endtask

  task automatic drive(input logic r, input logic kl, input logic [5:0] k,
                       input logic iv, input logic [5:0] d, input logic ordy);
    rst = r; key_load = kl; key_in = k; in_valid = iv; data_in = d; out_ready = ordy;
  endtask

  logic [5:0] KS7 [7] = '{6'b000001, 6'b100000, 6'b010000, 6'b001000,
                          6'b000100, 6'b000010, 6'b100001};

  initial begin
    m_mode = 0; m_n = 0; m_vld = 1'b0; m_dout = '0; m_seed = 6'd1;
    drive(1, 1, 6'd5, 1, 6'd0, 1);
    cyc();
    cyc();
    drive(0, 0, 6'd0, 1, 6'd7, 1);
    #1;
    check1("reset_in_ready", in_ready, 1'b0);
    cyc();
    check1("reset_keyed", keyed, 1'b0);
    check6("reset_data_out", data_out, 6'd0);

    // Seed and first two words
    drive(0, 1, 6'b000001, 0, 6'd0, 1); cyc();
    check1("load_keyed", keyed, 1'b1);
    drive(0, 0, 6'd0, 1, 6'b111111, 1); cyc();
    check6("first_word", data_out, 6'b111110);
    cyc();
    check6("second_word", data_out, 6'b011111);
    drive(0, 0, 6'd0, 0, 6'd0, 1); cyc();

    // Keystream across an expiry and a continuation reload
    drive(0, 1, 6'b000001, 0, 6'd0, 1); cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 6'd0, 1, 6'd0, 1); cyc();
      check6("keystream_a", data_out, KS7[i]);
    end
    check1("expired_flag", expired, 1'b1);
    check6("expired_cnt", word_cnt, 6'd4);
    check1("expired_last_valid", out_valid, 1'b1);
    cyc();
    check1("expired_drained", out_valid, 1'b0);
    check6("expired_cnt_hold", word_cnt, 6'd4);
    drive(0, 1, 6'b000100, 0, 6'd0, 1); cyc();
    check6("reload_cnt", word_cnt, 6'd0);
    for (int i = 4; i < 7; i++) begin
      drive(0, 0, 6'd0, 1, 6'd0, 1); cyc();
      check6("keystream_b", data_out, KS7[i]);
    end
    drive(0, 0, 6'd0, 0, 6'd0, 1); cyc();

    // Round trip
    drive(0, 1, 6'b010110, 0, 6'd0, 1); cyc();
    drive(0, 0, 6'd0, 1, 6'b101010, 1); cyc(); ct0 = data_out;
    drive(0, 0, 6'd0, 1, 6'b110011, 1); cyc(); ct1 = data_out;
    drive(0, 1, 6'b010110, 0, 6'd0, 1); cyc();
    drive(0, 0, 6'd0, 1, ct0, 1); cyc();
    check6("roundtrip_0", data_out, 6'b101010);
    drive(0, 0, 6'd0, 1, ct1, 1); cyc();
    check6("roundtrip_1", data_out, 6'b110011);

    // Backpressure
    drive(0, 1, 6'b000001, 0, 6'd0, 1); cyc();
    drive(0, 0, 6'd0, 1, 6'd0, 1); cyc();
    held = data_out;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 6'd0, 1, 6'd0, 0); cyc();
      check6("bp_stable", data_out, held);
    end
    drive(0, 0, 6'd0, 1, 6'd0, 1); cyc();
    check6("bp_second_ks", data_out, 6'b100000);

    // Zero seed, then reset while output pending
    drive(0, 1, 6'd0, 0, 6'd0, 1); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 6'd0, 1, 6'd0, 0); cyc();
`ifdef CIPHER_ZERO_SEED_GUARD_EN
      check6("zero_seed_guard", data_out, 6'b000001);
`else
      check6("zero_seed_pass", data_out, 6'b000000);
`endif
    end
    check1("pre_rst_valid", out_valid, 1'b1);
    drive(1, 1, 6'd9, 1, 6'd0, 0); cyc();
    check1("rst_drops_valid", out_valid, 1'b0);
    check1("rst_over_keyload", keyed, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) == 0,
            (m_mode != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom),
            1'($urandom), 6'($urandom), $urandom_range(0, 3) != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
